gardner_loop_ctrl: RTL and testbench
====================================

// Module: gardner_loop_ctrl
// PURPOSE
// - Sequencer and gain scheduler for the Gardner timing-recovery loop in the 32.768M receive domain.
// - Holds the corrector in reset, then runs a high-gain acquisition phase and switches to low-gain tracking.
// - Monitors the windowed mean |timing error| to declare lock, and drops back to acquisition on loss of lock.
// - Drives the corrector's sync reset and GARDNER_SHIFT; observes its symbol strobe and error_n.
// PARAMETERS
// - WIDTH        16   error word width (signed), matches corrector
// - WIN_LOG2     5    metric window = 2^WIN_LOG2 symbols (32)
// - ACQ_SYMS     256  minimum symbols spent in ACQUIRE before lock may be declared
// - RST_CYCLES   4    clocks corr_rst is held in RESET state
// - LOSS_WINDOWS 3    consecutive failing windows in TRACK before relock
// PORTS
// - clk          in   1      32.768M clock
// - rst_n        in   1      asynchronous active-low reset
// - en           in   1      loop enable; low forces IDLE
// - acq_shift    in   4      GARDNER_SHIFT used in ACQUIRE (smaller = higher gain)
// - trk_shift    in   4      GARDNER_SHIFT used in TRACK
// - lock_thresh  in   WIDTH  unsigned mean-|error| lock threshold
// - sym_clk      in   1      corrector clk_out (symbol strobe)
// - error_n      in   WIDTH  signed timing error fed to corrector
// - corr_rst     out  1      sync reset to corrector, active-high
// - gardner_shift out 4      loop gain to corrector
// - locked       out  1      high only in TRACK
// - state_o      out  2      0 IDLE, 1 RESET, 2 ACQUIRE, 3 TRACK
// - err_mean     out  WIDTH  last completed window mean |error|
// - win_done     out  1      one-clock pulse when err_mean updates
// BEHAVIOUR
// - Reset (rst_n=0): state IDLE, corr_rst=1, gardner_shift=0, locked=0, err_mean=0, win_done=0, all counters 0.
// - All outputs registered. sym_valid = rising edge of sym_clk (sym_clk registered once); 1-clock latency.
// - IDLE: corr_rst=1, gardner_shift<=acq_shift; en=1 -> RESET.
// - RESET: corr_rst=1 for exactly RST_CYCLES clocks, then -> ACQUIRE (corr_rst=0 from first ACQUIRE clock).
// - ACQUIRE: gardner_shift=acq_shift; symbol counter counts sym_valid, saturates at ACQ_SYMS.
//   At win_done: if sym count==ACQ_SYMS and err_mean_new < lock_thresh -> TRACK, locked=1 next clock.
// - TRACK: gardner_shift=trk_shift. At win_done: mean >= thresh increments loss counter, mean < thresh clears it.
//   Loss counter reaching LOSS_WINDOWS -> ACQUIRE, locked=0, sym count/loss count cleared; corrector NOT reset.
// - gardner_shift updates the same clock the state register changes; acq/trk_shift sampled continuously in state.
// - Metric: |error_n| on each sym_valid; -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1. Accumulator unsigned
//   WIDTH+WIN_LOG2 bits (no overflow). After 2^WIN_LOG2 symbols: err_mean<=acc>>WIN_LOG2, win_done=1,
//   acc restarts with 0 (symbol arriving on win_done clock counts into the new window).
// - Window accumulator and counter cleared on entering ACQUIRE or TRACK; idle in IDLE/RESET.
// - en=0 in any state -> IDLE next clock (overrides simultaneous win_done/transition); locked=0, corr_rst=1.
// - sym_valid ignored in IDLE and RESET. rst_n asserted mid-operation: immediate async return to reset values.
// - Comparisons unsigned on err_mean vs lock_thresh; equality counts as failing.
// STRUCTURE
// - Shared package: state encoding constants (ST_IDLE..ST_TRACK), WIDTH default.
// - One sub-module: gardner_err_meter (abs/saturate, accumulate, window count, err_mean/win_done).
// - Top holds FSM, RESET cycle counter, ACQ symbol counter, loss counter, output registers.
// TESTING
// - Reset/enable: rst_n low, en=1 -> all outputs reset values; release -> corr_rst high 4 clocks, state_o 1 then 2.
// - Acquisition: acq_shift=2, trk_shift=6, thresh=100, |error_n|=50 per symbol -> locked rises at first win_done
//   after 256 symbols (symbol 256), gardner_shift 2 -> 6 same clock state_o=3.
// - Metric math: error_n=-32768 for 32 symbols -> err_mean=32767; alternating +40/-20 -> err_mean=30.
// - Loss of lock: in TRACK set |error_n|=200 -> three win_done pulses then state_o=2, locked=0, corr_rst stays 0;
//   two bad windows then one good -> stays TRACK.
// - Threshold edge: mean exactly == thresh in ACQUIRE -> no lock; thresh+1 -> lock.
// - en drop coincident with win_done that would lock -> IDLE, locked=0, corr_rst=1 next clock; async rst mid-TRACK.

Source files
------------

// File: rtl/gardner_loop_ctrl_pkg.sv
// Shared definitions for the Gardner timing-loop sequencer: state encoding
// and default widths used by the controller and its error meter.
package gardner_loop_ctrl_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int WIN_LOG2_DEF = 5;
    localparam int SHIFT_W      = 4;

    // Encoding is visible on state_o, so the values are fixed explicitly.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESET   = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_TRACK   = 2'd3
    } loop_state_t;

endpackage

// File: rtl/gardner_err_meter.sv
// Windowed mean |timing error| meter. Each accepted symbol contributes its
// saturated magnitude; after 2^WIN_LOG2 symbols the mean is published with a
// one-clock win_done pulse and the accumulator restarts from zero.
module gardner_err_meter
    import gardner_loop_ctrl_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    active,
    input  logic                    sym_valid,
    input  logic signed [WIDTH-1:0] error_n,
    output logic        [WIDTH-1:0] err_mean,
    output logic                    win_done
);

    localparam int ACC_W = WIDTH + WIN_LOG2;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0]    mag;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIN_LOG2-1:0] cnt;

    // Magnitude of the error; the most negative code has no positive twin,
    // so it is clamped to the largest positive value.
    always_comb begin
        mag = error_n;
        if (error_n == MOST_NEG) begin
            mag = MOST_POS;
        end else if (error_n[WIDTH-1]) begin
            mag = ~error_n + 1'b1;
        end
        acc_sum = acc + ACC_W'(mag);
    end

    // Accumulate one window; clear has priority so a fresh state starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            err_mean <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (active && sym_valid) begin
                if (cnt == '1) begin
                    err_mean <= acc_sum[ACC_W-1:WIN_LOG2];
                    win_done <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gardner_loop_ctrl.sv
// Sequencer and gain scheduler for the Gardner timing-recovery loop.
// Holds the corrector in reset, acquires with high gain, tracks with low gain
// once the windowed mean |error| is below threshold, and falls back to
// acquisition (without resetting the corrector) after repeated bad windows.
module gardner_loop_ctrl
    import gardner_loop_ctrl_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int WIN_LOG2     = WIN_LOG2_DEF,
    parameter int ACQ_SYMS     = 256,
    parameter int RST_CYCLES   = 4,
    parameter int LOSS_WINDOWS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [SHIFT_W-1:0]       acq_shift,
    input  logic [SHIFT_W-1:0]       trk_shift,
    input  logic [WIDTH-1:0]         lock_thresh,
    input  logic                     sym_clk,
    input  logic signed [WIDTH-1:0]  error_n,
    output logic                     corr_rst,
    output logic [SHIFT_W-1:0]       gardner_shift,
    output logic                     locked,
    output logic [1:0]               state_o,
    output logic [WIDTH-1:0]         err_mean,
    output logic                     win_done
);

    localparam int SYM_W  = $clog2(ACQ_SYMS + 1);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int LOSS_W = $clog2(LOSS_WINDOWS + 1);

    localparam logic [SYM_W-1:0]  ACQ_SYMS_C = SYM_W'(ACQ_SYMS);
    localparam logic [RST_W-1:0]  RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST  = LOSS_W'(LOSS_WINDOWS - 1);

    loop_state_t       state_q;
    loop_state_t       state_d;
    logic [RST_W-1:0]  rst_cnt_q;
    logic [RST_W-1:0]  rst_cnt_d;
    logic [SYM_W-1:0]  sym_cnt_q;
    logic [SYM_W-1:0]  sym_cnt_d;
    logic [LOSS_W-1:0] loss_cnt_q;
    logic [LOSS_W-1:0] loss_cnt_d;
    logic              sym_d;
    logic              sym_valid;
    logic              meter_active;
    logic              meter_clear;

    // Symbol strobe edge: sym_clk registered once, rising edge marks a symbol.
    assign sym_valid    = sym_clk & ~sym_d;
    assign meter_active = (state_q == ST_ACQUIRE) || (state_q == ST_TRACK);
    assign meter_clear  = (state_d != state_q) &&
                          ((state_d == ST_ACQUIRE) || (state_d == ST_TRACK));
    assign state_o      = state_q;

    gardner_err_meter #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) u_meter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (meter_clear),
        .active    (meter_active),
        .sym_valid (sym_valid),
        .error_n   (error_n),
        .err_mean  (err_mean),
        .win_done  (win_done)
    );

    // Next-state and counter updates; loss of enable overrides everything.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        loss_cnt_d = loss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                rst_cnt_d  = '0;
                sym_cnt_d  = '0;
                loss_cnt_d = '0;
                if (en) begin
                    state_d = ST_RESET;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_ACQUIRE;
                    rst_cnt_d = '0;
                    sym_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (sym_valid && (sym_cnt_q != ACQ_SYMS_C)) begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
                if (win_done && (sym_cnt_q == ACQ_SYMS_C) && (err_mean < lock_thresh)) begin
                    state_d    = ST_TRACK;
                    loss_cnt_d = '0;
                end
            end
            ST_TRACK: begin
                if (win_done) begin
                    if (err_mean >= lock_thresh) begin
                        if (loss_cnt_q == LOSS_LAST) begin
                            state_d    = ST_ACQUIRE;
                            sym_cnt_d  = '0;
                            loss_cnt_d = '0;
                        end else begin
                            loss_cnt_d = loss_cnt_q + 1'b1;
                        end
                    end else begin
                        loss_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!en) begin
            state_d = ST_IDLE;
        end
    end

    // State, counters and outputs registered together so gain follows state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= '0;
            sym_cnt_q     <= '0;
            loss_cnt_q    <= '0;
            sym_d         <= 1'b0;
            corr_rst      <= 1'b1;
            gardner_shift <= '0;
            locked        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            sym_cnt_q     <= sym_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            sym_d         <= sym_clk;
            corr_rst      <= (state_d == ST_IDLE) || (state_d == ST_RESET);
            locked        <= (state_d == ST_TRACK);
            gardner_shift <= (state_d == ST_TRACK) ? trk_shift : acq_shift;
        end
    end

endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// Bench for gardner_loop_ctrl: scenario tasks with inline checks and an
// expected-mean queue filled as symbol windows are driven.
module tb_gardner_loop_ctrl;

    localparam int WIDTH = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic [3:0]              acq_shift;
    logic [3:0]              trk_shift;
    logic [WIDTH-1:0]        lock_thresh;
    logic                    sym_clk;
    logic signed [WIDTH-1:0] error_n;
    logic                    corr_rst;
    logic [3:0]              gardner_shift;
    logic                    locked;
    logic [1:0]              state_o;
    logic [WIDTH-1:0]        err_mean;
    logic                    win_done;

    logic [WIDTH-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gardner_loop_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .acq_shift     (acq_shift),
        .trk_shift     (trk_shift),
        .lock_thresh   (lock_thresh),
        .sym_clk       (sym_clk),
        .error_n       (error_n),
        .corr_rst      (corr_rst),
        .gardner_shift (gardner_shift),
        .locked        (locked),
        .state_o       (state_o),
        .err_mean      (err_mean),
        .win_done      (win_done)
    );

    function automatic int abs_sat(input int v);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    // One symbol: sym_clk high for a clock then low; any window result is scored.
    task automatic send_sym(input int v);
        logic [WIDTH-1:0] exp;
        error_n = v[WIDTH-1:0];
        for (int ph = 0; ph < 2; ph++) begin
            sym_clk = (ph == 0);
            @(negedge clk);
            if (win_done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL win_done_unexpected: err_mean=%0d, required no window", err_mean);
                end else begin
                    exp = exp_q.pop_front();
                    if (err_mean !== exp) begin
                        bad++;
                        $display("FAIL err_mean: got %0d required %0d", err_mean, exp);
                    end
                end
            end
        end
    endtask

    // 32 symbols alternating a/b; expected mean pushed before driving.
    task automatic send_window(input int a, input int b);
        int m;
        m = (16 * abs_sat(a) + 16 * abs_sat(b)) / 32;
        exp_q.push_back(m[WIDTH-1:0]);
        for (int i = 0; i < 32; i++) begin
            send_sym((i % 2 == 0) ? a : b);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL window_missing: pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic restart();
        bit ok;
        en = 1'b0;
        sym_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (state_o !== 2'd0 || corr_rst !== 1'b1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL idle_on_disable: state=%0d corr_rst=%0b locked=%0b required 0/1/0",
                     state_o, corr_rst, locked);
        end
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (state_o == 2'd2) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL restart_timeout: state=%0d required 2", state_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        acq_shift = 4'd2;
        trk_shift = 4'd6;
        lock_thresh = '0;
        sym_clk = 1'b0;
        error_n = '0;
        repeat (3) @(negedge clk);
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d required 0", state_o); end
        total++; if (corr_rst !== 1'b1) begin bad++; $display("FAIL rst_corr_rst: got %0b required 1", corr_rst); end
        total++; if (gardner_shift !== 4'd0) begin bad++; $display("FAIL rst_shift: got %0d required 0", gardner_shift); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %0b required 0", locked); end
        total++; if (err_mean !== '0) begin bad++; $display("FAIL rst_err_mean: got %0d required 0", err_mean); end
        total++; if (win_done !== 1'b0) begin bad++; $display("FAIL rst_win_done: got %0b required 0", win_done); end
    endtask

    task automatic test_enable_seq();
        int n_rst;
        int bad_cr;
        n_rst = 0;
        bad_cr = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (state_o == 2'd1) begin
                n_rst++;
                if (corr_rst !== 1'b1) bad_cr++;
            end else if (state_o == 2'd2) begin
                break;
            end
        end
        total++; if (n_rst != 4) begin bad++; $display("FAIL reset_len: got %0d clocks required 4", n_rst); end
        total++; if (bad_cr != 0) begin bad++; $display("FAIL reset_corr_rst: %0d low clocks required 0", bad_cr); end
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL enter_acq: state=%0d required 2", state_o); end
        total++; if (corr_rst !== 1'b0) begin bad++; $display("FAIL acq_corr_rst: got %0b required 0", corr_rst); end
        total++; if (gardner_shift !== 4'd2) begin bad++; $display("FAIL acq_shift: got %0d required 2", gardner_shift); end
    endtask

    task automatic test_metric();
        int a;
        int b;
        lock_thresh = '0;
        send_window(-32768, -32768);
        send_window(40, -20);
        a = int'($urandom_range(65535)) - 32768;
        b = int'($urandom_range(65535)) - 32768;
        send_window(a, b);
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL metric_state: got %0d required 2", state_o); end
    endtask

    task automatic test_acquisition();
        restart();
        lock_thresh = 16'd100;
        for (int w = 0; w < 7; w++) send_window(50, -50);
        total++; if (state_o !== 2'd2 || locked !== 1'b0 || gardner_shift !== 4'd2) begin
            bad++;
            $display("FAIL early_lock: state=%0d locked=%0b shift=%0d required 2/0/2", state_o, locked, gardner_shift);
        end
        send_window(50, -50);
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL lock_state: got %0d required 3", state_o); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked: got %0b required 1", locked); end
        total++; if (gardner_shift !== 4'd6) begin bad++; $display("FAIL lock_shift: got %0d required 6", gardner_shift); end
        total++; if (corr_rst !== 1'b0) begin bad++; $display("FAIL lock_corr_rst: got %0b required 0", corr_rst); end
    endtask

    task automatic test_loss();
        send_window(200, -200);
        send_window(200, 200);
        send_window(50, 50);
        send_window(-200, 200);
        send_window(200, 200);
        total++; if (state_o !== 2'd3 || locked !== 1'b1) begin
            bad++;
            $display("FAIL loss_cleared: state=%0d locked=%0b required 3/1", state_o, locked);
        end
        send_window(200, -200);
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL relock_state: got %0d required 2", state_o); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_locked: got %0b required 0", locked); end
        total++; if (corr_rst !== 1'b0) begin bad++; $display("FAIL relock_corr_rst: got %0b required 0", corr_rst); end
        total++; if (gardner_shift !== 4'd2) begin bad++; $display("FAIL relock_shift: got %0d required 2", gardner_shift); end
        send_window(50, 50);
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL relock_symcount: state=%0d required 2", state_o); end
    endtask

    task automatic test_threshold();
        restart();
        lock_thresh = 16'd50;
        for (int w = 0; w < 8; w++) send_window(50, -50);
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL thresh_equal: state=%0d required 2", state_o); end
        lock_thresh = 16'd51;
        send_window(-50, 50);
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL thresh_plus1: state=%0d required 3", state_o); end
    endtask

    task automatic test_en_drop();
        logic [WIDTH-1:0] exp;
        restart();
        lock_thresh = 16'd100;
        for (int w = 0; w < 7; w++) send_window(50, 50);
        for (int i = 0; i < 31; i++) send_sym(50);
        exp_q.push_back(16'd50);
        error_n = 16'sd50;
        sym_clk = 1'b1;
        @(negedge clk);
        total++;
        if (win_done !== 1'b1) begin
            bad++;
            $display("FAIL drop_win_done: got %0b required 1", win_done);
            exp_q.delete();
        end else begin
            exp = exp_q.pop_front();
            if (err_mean !== exp) begin
                bad++;
                $display("FAIL drop_err_mean: got %0d required %0d", err_mean, exp);
            end
        end
        en = 1'b0;
        sym_clk = 1'b0;
        @(negedge clk);
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL drop_state: got %0d required 0", state_o); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL drop_locked: got %0b required 0", locked); end
        total++; if (corr_rst !== 1'b1) begin bad++; $display("FAIL drop_corr_rst: got %0b required 1", corr_rst); end
    endtask

    task automatic test_async_reset();
        restart();
        lock_thresh = 16'd100;
        for (int w = 0; w < 8; w++) send_window(50, -50);
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL pre_async_track: state=%0d required 3", state_o); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL async_state: got %0d required 0", state_o); end
        total++; if (corr_rst !== 1'b1) begin bad++; $display("FAIL async_corr_rst: got %0b required 1", corr_rst); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL async_locked: got %0b required 0", locked); end
        total++; if (gardner_shift !== 4'd0) begin bad++; $display("FAIL async_shift: got %0d required 0", gardner_shift); end
        total++; if (err_mean !== '0) begin bad++; $display("FAIL async_err_mean: got %0d required 0", err_mean); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_enable_seq();
        test_metric();
        test_acquisition();
        test_loss();
        test_threshold();
        test_en_drop();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
